rsa32_arb: RTL

- Round-robin arbiter and sequencer that shares one rsa32 modular-exponentiation engine among NREQ requesters.
- Sits between the per-master bus slaves and the single engine instance.
- Latches the winning requester's operands and drives a clean start edge to the engine.
- Waits for the engine's end window, captures the result and returns it with a one-cycle done pulse to the owning requester.

---
 rtl/rsa32_arb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rsa32_arb.sv
// rsa32_arb: round-robin arbiter/sequencer sharing one rsa32 modexp engine
// among NREQ requesters.
//
// Optional feature macro: RSA_ARB_TIMEOUT_EN (engine watchdog, TIMEOUT_CYC).
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_req[NREQ]            per-requester request level
//   i_base/i_exp/i_N       packed 32-bit operands, requester k at [32k+31:32k]
//   o_gnt[NREQ]            one-hot owner, held from grant through o_done
//   o_done[NREQ]           one-cycle completion pulse to the owner
//   o_err, o_result        completion status/result, valid with o_done
//   o_busy                 high whenever the sequencer is not idle
//   o_eng_start            one-cycle start level to the engine
//   o_eng_base/exp/N       operands latched at grant
//   i_eng_result, i_eng_end engine result and multi-cycle end window
module rsa32_arb #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NREQ-1:0]      i_req,
  input  logic [32*NREQ-1:0]   i_base,
  input  logic [32*NREQ-1:0]   i_exp,
  input  logic [32*NREQ-1:0]   i_N,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_done,
  output logic                 o_err,
  output logic [31:0]          o_result,
  output logic                 o_busy,
  output logic                 o_eng_start,
  output logic [31:0]          o_eng_base,
  output logic [31:0]          o_eng_exp,
  output logic [31:0]          o_eng_N,
  input  logic [31:0]          i_eng_result,
  input  logic                 i_eng_end
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("rsa32_arb: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_END,
    S_WAIT_FALL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic            err_q;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic            tmo;

  logic [31:0] base_a [NREQ];
  logic [31:0] exp_a  [NREQ];
  logic [31:0] n_a    [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign base_a[k] = i_base[32*k +: 32];
    assign exp_a[k]  = i_exp[32*k +: 32];
    assign n_a[k]    = i_N[32*k +: 32];
  end

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_ISSUE:                 cnt_q <= '0;
        S_WAIT_END, S_WAIT_FALL: cnt_q <= cnt_q + 1'b1;
        default:                 cnt_q <= cnt_q;
      endcase
    end
  end

  // Fires on the wait cycle whose increment brings the count to the limit.
  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // First set request at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx  = (32'(ptr_q) + i) % NREQ;
      cand = PW'(idx);
      if (!win_vld && i_req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (win_vld) state_d = (n_a[win] == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_END;
      S_WAIT_END:  if (i_eng_end) state_d = S_WAIT_FALL;
                   else if (tmo) state_d = S_DONE;
      S_WAIT_FALL: if (!i_eng_end || tmo) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      err_q      <= 1'b0;
      o_result   <= '0;
      o_eng_base <= '0;
      o_eng_exp  <= '0;
      o_eng_N    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q      <= NREQ'(1) << win;
            ptr_q      <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            o_eng_base <= base_a[win];
            o_eng_exp  <= exp_a[win];
            o_eng_N    <= n_a[win];
            err_q      <= (n_a[win] == '0);
            if (n_a[win] == '0) o_result <= '0;
          end
        end
        S_WAIT_END: begin
          if (!i_eng_end && tmo) begin
            err_q    <= 1'b1;
            o_result <= '0;
          end
        end
        S_WAIT_FALL: begin
          // Sample on the falling end so the engine's registered result is settled.
          if (!i_eng_end) begin
            o_result <= i_eng_result;
          end else if (tmo) begin
            err_q    <= 1'b1;
            o_result <= '0;
          end
        end
        S_DONE:  gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = (state_q == S_DONE) ? gnt_q : '0;
  assign o_err       = (state_q == S_DONE) && err_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_eng_start = (state_q == S_ISSUE);

endmodule
